// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction-fetch and data buses.
// Data wins by default; an ibus that keeps losing to dbus is eventually forced through.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [7:0]        m_strobe,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic              ownerData_q, ownerData_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [2:0]        reqSize_q, reqSize_d;
  logic [7:0]        reqStrobe_q, reqStrobe_d;
  logic [DATA_W-1:0] reqData_q, reqData_d;
  logic [3:0]        starveCnt_q, starveCnt_d;
  logic              addrOk, dataOk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ownerData_q <= 1'b0;
      reqAddr_q   <= '0;
      reqSize_q   <= '0;
      reqStrobe_q <= '0;
      reqData_q   <= '0;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ownerData_q <= ownerData_d;
      reqAddr_q   <= reqAddr_d;
      reqSize_q   <= reqSize_d;
      reqStrobe_q <= reqStrobe_d;
      reqData_q   <= reqData_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // dbus wins unless ibus is also waiting and has already lost LIMIT times in a row
  always_comb begin
    state_d     = state_q;
    ownerData_d = ownerData_q;
    reqAddr_d   = reqAddr_q;
    reqSize_d   = reqSize_q;
    reqStrobe_d = reqStrobe_q;
    reqData_d   = reqData_q;
    starveCnt_d = starveCnt_q;
    unique case (state_q)
      IDLE: begin
        if (dreq_valid && !(ireq_valid && starveCnt_q == LIMIT)) begin
          state_d     = REQ;
          ownerData_d = 1'b1;
          reqAddr_d   = dreq_addr;
          reqSize_d   = dreq_size;
          reqStrobe_d = dreq_strobe;
          reqData_d   = dreq_data;
          if (ireq_valid && starveCnt_q != LIMIT) starveCnt_d = starveCnt_q + 4'd1;
        end else if (ireq_valid) begin
          state_d     = REQ;
          ownerData_d = 1'b0;
          reqAddr_d   = ireq_addr;
          reqSize_d   = 3'd2;
          reqStrobe_d = '0;
          reqData_d   = '0;
          starveCnt_d = '0;
        end
      end
      REQ: begin
        if (m_addr_ok) state_d = m_data_ok ? IDLE : WAIT;
      end
      WAIT: begin
        if (m_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addrOk        = (state_q == REQ) && m_addr_ok;
    dataOk        = (addrOk && m_data_ok) || ((state_q == WAIT) && m_data_ok);
    iresp_addr_ok = addrOk && !ownerData_q;
    dresp_addr_ok = addrOk && ownerData_q;
    iresp_data_ok = dataOk && !ownerData_q;
    dresp_data_ok = dataOk && ownerData_q;
    dresp_data    = '0;
    iresp_data    = '0;
    if (dataOk && ownerData_q) dresp_data = m_rdata;
    if (dataOk && !ownerData_q) iresp_data = reqAddr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
  end

  assign m_valid  = (state_q == REQ);
  assign m_addr   = reqAddr_q;
  assign m_size   = reqSize_q;
  assign m_strobe = reqStrobe_q;
  assign m_data   = reqData_q;

endmodule
